multistage_priority_demux: RTL and testbench

- Pipelined one-to-many distributor for attribute results. It takes a single valid/data stream tagged with a destination group index and delivers each word to exactly one of DATA_GROUPS output slices.
- Supports per-group backpressure.
- It is the fan-out counterpart of the packet analyzer's multistage priority mux. It sits between the attribute producer and the per-group consumers in the monitoring output port lookup path.

---
 rtl/multistage_priority_demux_if.sv | 26 ++
 rtl/multistage_priority_demux.sv | 128 ++++++++++++
 tb/tb_multistage_priority_demux.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/multistage_priority_demux_if.sv
// Stream bundle for multistage_priority_demux: one tagged input stream and per-group output slices.
// The producer/consumer side uses the master modport; the demux uses slave.
interface multistage_priority_demux_if #(
  parameter int unsigned ATTRIBUTE_DATA_WIDTH = 135,
  parameter int unsigned DATA_GROUPS          = 4,
  parameter int unsigned SEL_WIDTH            = 2
);
  logic                                        valid_i;
  logic [ATTRIBUTE_DATA_WIDTH-1:0]             data_i;
  logic [SEL_WIDTH-1:0]                        sel_i;
  logic                                        ready_o;
  logic [DATA_GROUPS-1:0]                      valid_groups_o;
  logic [DATA_GROUPS*ATTRIBUTE_DATA_WIDTH-1:0] data_groups_o;
  logic [DATA_GROUPS-1:0]                      ready_groups_i;
  logic [15:0]                                 drop_count_o;

  modport master (
    output valid_i, data_i, sel_i, ready_groups_i,
    input  ready_o, valid_groups_o, data_groups_o, drop_count_o
  );

  modport slave (
    input  valid_i, data_i, sel_i, ready_groups_i,
    output ready_o, valid_groups_o, data_groups_o, drop_count_o
  );
endinterface

// File: rtl/multistage_priority_demux.sv
// Pipelined one-to-many distributor: each accepted word leaves on exactly one group slice, in order.
// Optional broadcast of sel == all-ones is enabled by MULTISTAGE_PRIORITY_DEMUX_BROADCAST_EN.
module multistage_priority_demux #(
  parameter int unsigned ATTRIBUTE_DATA_WIDTH = 135,
  parameter int unsigned DIVISION_FACTOR      = 2,
  parameter int unsigned DATA_GROUPS          = 4,
  parameter int unsigned SEL_WIDTH            = 2
) (
  input logic                         clk,
  input logic                         reset,
  multistage_priority_demux_if.slave  bus
);
  localparam int unsigned W = ATTRIBUTE_DATA_WIDTH;
  localparam int unsigned G = DATA_GROUPS;
  localparam int unsigned L = $clog2(DIVISION_FACTOR) + 1;
  localparam int unsigned H = L - 1;

  logic [L-1:0]         slot_valid;
  logic [W-1:0]         slot_data [L];
  logic [SEL_WIDTH-1:0] slot_sel  [L];
  logic [15:0]          drop_count;

  logic                 adv_c;
  logic                 in_range_c;
  logic                 load_valid_c;
  logic                 drop_c;
  logic                 head_ready_c;
  logic [G-1:0]         head_hit_c;
  logic [G-1:0]         valid_groups_c;
  logic [G*W-1:0]       data_groups_c;

`ifdef MULTISTAGE_PRIORITY_DEMUX_BROADCAST_EN
  logic [G-1:0]         done_mask;
  logic                 bcast_in_c;
  logic                 head_bcast_c;

  assign bcast_in_c   = &bus.sel_i;
  assign head_bcast_c = &slot_sel[H];
`endif

  // Head decode, global advance and slot-0 load/drop qualification.
  always_comb begin
    head_hit_c     = '0;
    valid_groups_c = '0;
    adv_c          = 1'b1;
    load_valid_c   = 1'b0;
    drop_c         = 1'b0;
    data_groups_c  = '0;

    for (int unsigned g = 0; g < G; g++) begin
      head_hit_c[g] = (32'(slot_sel[H]) == g);
    end
    head_ready_c = |(head_hit_c & bus.ready_groups_i);
    in_range_c   = (32'(bus.sel_i) < G);

`ifdef MULTISTAGE_PRIORITY_DEMUX_BROADCAST_EN
    if (slot_valid[H] && head_bcast_c) begin
      // Broadcast head offers itself to every group not yet served.
      valid_groups_c = ~done_mask;
      adv_c          = &(done_mask | bus.ready_groups_i);
    end else begin
      valid_groups_c = slot_valid[H] ? head_hit_c : '0;
      adv_c          = ~slot_valid[H] | head_ready_c;
    end
    load_valid_c = bus.valid_i & adv_c & (in_range_c | bcast_in_c);
    drop_c       = bus.valid_i & adv_c & ~in_range_c & ~bcast_in_c;
`else
    valid_groups_c = slot_valid[H] ? head_hit_c : '0;
    adv_c          = ~slot_valid[H] | head_ready_c;
    load_valid_c   = bus.valid_i & adv_c & in_range_c;
    drop_c         = bus.valid_i & adv_c & ~in_range_c;
`endif

    for (int unsigned g = 0; g < G; g++) begin
      if (valid_groups_c[g]) begin
        data_groups_c[g*W +: W] = slot_data[H];
      end
    end
  end

  // Shift register of slots; the whole pipe stalls when the head cannot retire.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_valid <= '0;
      for (int unsigned i = 0; i < L; i++) begin
        slot_data[i] <= '0;
        slot_sel[i]  <= '0;
      end
    end else if (adv_c) begin
      for (int unsigned i = 1; i < L; i++) begin
        slot_valid[i] <= slot_valid[i-1];
        slot_data[i]  <= slot_data[i-1];
        slot_sel[i]   <= slot_sel[i-1];
      end
      slot_valid[0] <= load_valid_c;
      slot_data[0]  <= bus.data_i;
      slot_sel[0]   <= bus.sel_i;
    end
  end

`ifdef MULTISTAGE_PRIORITY_DEMUX_BROADCAST_EN
  // Tracks which groups already took the broadcast head; cleared when it retires.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done_mask <= '0;
    end else if (adv_c) begin
      done_mask <= '0;
    end else if (slot_valid[H] && head_bcast_c) begin
      done_mask <= done_mask | (valid_groups_c & bus.ready_groups_i);
    end
  end
`endif

  // Saturating count of words accepted with an out-of-range group index.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_count <= '0;
    end else if (drop_c && (drop_count != 16'hFFFF)) begin
      drop_count <= drop_count + 16'd1;
    end
  end

  assign bus.ready_o        = adv_c;
  assign bus.valid_groups_o = valid_groups_c;
  assign bus.data_groups_o  = data_groups_c;
  assign bus.drop_count_o   = drop_count;

endmodule

// File: tb/tb_multistage_priority_demux.sv
// Self-checking bench for multistage_priority_demux: directed steps plus random traffic vs a queue model.
// Broadcast checks are included when MULTISTAGE_PRIORITY_DEMUX_BROADCAST_EN is defined.
module tb_multistage_priority_demux;
  localparam int unsigned W  = 135;
  localparam int unsigned G  = 4;
  localparam int unsigned S  = 2;
  localparam int unsigned L  = 2;
  localparam int unsigned G3 = 3;
  localparam int unsigned S3 = 3;
  localparam int unsigned DW = G * W;

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  multistage_priority_demux_if #(.ATTRIBUTE_DATA_WIDTH(W), .DATA_GROUPS(G),  .SEL_WIDTH(S))  bus  ();
  multistage_priority_demux_if #(.ATTRIBUTE_DATA_WIDTH(W), .DATA_GROUPS(G3), .SEL_WIDTH(S3)) bus3 ();

  multistage_priority_demux #(
    .ATTRIBUTE_DATA_WIDTH(W), .DIVISION_FACTOR(2), .DATA_GROUPS(G), .SEL_WIDTH(S)
  ) dut (.clk(clk), .reset(reset), .bus(bus));

  multistage_priority_demux #(
    .ATTRIBUTE_DATA_WIDTH(W), .DIVISION_FACTOR(2), .DATA_GROUPS(G3), .SEL_WIDTH(S3)
  ) dut3 (.clk(clk), .reset(reset), .bus(bus3));

  // Reference: the pipe is a queue of L entries, oldest at index 0.
  typedef struct {
    bit           v;
    bit [S-1:0]   sel;
    bit [W-1:0]   data;
  } ent_t;

  ent_t       pipe[$];
  bit [G-1:0] bdone;

  function automatic bit is_bcast(input bit [S-1:0] s);
`ifdef MULTISTAGE_PRIORITY_DEMUX_BROADCAST_EN
    return (s == {S{1'b1}});
`else
    return (s == {S{1'b1}}) && 1'b0;
`endif
  endfunction

  function automatic bit [W-1:0] rnd_data();
    return W'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
  endfunction

  task automatic model_reset();
    ent_t e;
    e.v = 1'b0; e.sel = '0; e.data = '0;
    pipe.delete();
    for (int i = 0; i < int'(L); i++) pipe.push_back(e);
    bdone = '0;
  endtask

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock of the main DUT: drive at negedge, compare against the model, advance the model.
  task automatic step(input bit v, input bit [S-1:0] s, input bit [W-1:0] d, input bit [G-1:0] r);
    ent_t       head;
    ent_t       e;
    bit [G-1:0] ev;
    bit [DW-1:0] ed;
    bit         adv;
    bus.valid_i = v; bus.sel_i = s; bus.data_i = d; bus.ready_groups_i = r;
    #1;
    head = pipe[0];
    ev   = '0;
    adv  = 1'b1;
    if (head.v && is_bcast(head.sel)) begin
      ev  = ~bdone;
      adv = ((bdone | r) == {G{1'b1}});
    end else if (head.v) begin
      ev[head.sel] = 1'b1;
      adv          = r[head.sel];
    end
    ed = '0;
    for (int g = 0; g < int'(G); g++) if (ev[g]) ed[g*W +: W] = head.data;
    check("ready_o",      DW'(bus.ready_o),        DW'(adv));
    check("valid_groups", DW'(bus.valid_groups_o), DW'(ev));
    check("data_groups",  bus.data_groups_o,       ed);
    check("drop_count",   DW'(bus.drop_count_o),   DW'(16'd0));
    if (head.v && is_bcast(head.sel)) bdone = adv ? '0 : (bdone | (ev & r));
    if (adv) begin
      head   = pipe.pop_front();
      e.v    = v;
      e.sel  = s;
      e.data = d;
      pipe.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.valid_i  = 1'b0;
    bus3.valid_i = 1'b0;
    #1;
    check("rst_valid",  DW'(bus.valid_groups_o), DW'(4'b0000));
    check("rst_data",   bus.data_groups_o,       DW'(0));
    check("rst_ready",  DW'(bus.ready_o),        DW'(1'b1));
    check("rst_drop",   DW'(bus.drop_count_o),   DW'(16'd0));
    check("rst_drop3",  DW'(bus3.drop_count_o),  DW'(16'd0));
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    reset = 1'b0;
    bus.valid_i = 1'b0; bus.sel_i = '0; bus.data_i = '0; bus.ready_groups_i = '1;
    bus3.valid_i = 1'b0; bus3.sel_i = '0; bus3.data_i = '0; bus3.ready_groups_i = '1;
    model_reset();
    @(negedge clk);
    do_reset();

    // Idle after reset
    step(1'b0, 2'd0, '0, 4'b1111);
    step(1'b0, 2'd0, '0, 4'b1111);

    // Routing and latency
    step(1'b1, 2'd0, W'(8'h11), 4'b1111);
    step(1'b1, 2'd1, W'(8'h22), 4'b1111);
    step(1'b1, 2'd2, W'(8'h33), 4'b1111);
    step(1'b1, 2'd3, W'(8'h44), 4'b1111);
    repeat (3) step(1'b0, 2'd0, '0, 4'b1111);

    // Backpressure on group 2 for five cycles
    step(1'b1, 2'd2, W'(8'hAB), 4'b1011);
    step(1'b1, 2'd0, W'(8'hCD), 4'b1011);
    repeat (5) step(1'b1, 2'd1, W'(8'hEF), 4'b1011);
    step(1'b1, 2'd1, W'(8'hEF), 4'b1111);
    repeat (3) step(1'b0, 2'd0, '0, 4'b1111);

    // Foreign ready bits do not release the head
    step(1'b1, 2'd1, W'(8'h77), 4'b1111);
    step(1'b0, 2'd0, '0, 4'b1111);
    repeat (3) step(1'b0, 2'd0, '0, 4'b1101);
    step(1'b0, 2'd0, '0, 4'b1111);
    step(1'b0, 2'd0, '0, 4'b1111);

`ifdef MULTISTAGE_PRIORITY_DEMUX_BROADCAST_EN
    // Broadcast served in two halves
    step(1'b1, 2'd3, W'(8'h5A), 4'b1111);
    step(1'b0, 2'd0, '0, 4'b1111);
    step(1'b0, 2'd0, '0, 4'b0011);
    step(1'b0, 2'd0, '0, 4'b1100);
    step(1'b0, 2'd0, '0, 4'b1111);
`endif

    // Reset with words in flight
    step(1'b1, 2'd0, W'(8'h91), 4'b1111);
    step(1'b1, 2'd2, W'(8'h92), 4'b0000);
    do_reset();
    repeat (3) step(1'b0, 2'd0, '0, 4'b1111);

    // Random traffic
    repeat (400) step(1'($urandom_range(0, 1)), S'($urandom_range(0, G - 1)), rnd_data(), G'($urandom()));
    repeat (4) step(1'b0, 2'd0, '0, 4'b1111);

    // Out-of-range drops and counter saturation on the three-group instance
    bus3.sel_i   = 3'd3;
    bus3.data_i  = W'(8'h3C);
    bus3.valid_i = 1'b1;
    repeat (3) begin
      #1;
      check("drop_ready3", DW'(bus3.ready_o),        DW'(1'b1));
      check("drop_valid3", DW'(bus3.valid_groups_o), DW'(3'b000));
      check("drop_data3",  DW'(bus3.data_groups_o),  DW'(0));
      @(negedge clk);
    end
    bus3.valid_i = 1'b0;
    #1;
    check("drop_cnt3", DW'(bus3.drop_count_o), DW'(16'd3));
    @(negedge clk);
    bus3.valid_i = 1'b1;
    repeat (65531) @(negedge clk);
    bus3.valid_i = 1'b0;
    #1;
    check("drop_cnt_fffe", DW'(bus3.drop_count_o), DW'(16'hFFFE));
    @(negedge clk);
    bus3.valid_i = 1'b1;
    repeat (2) @(negedge clk);
    bus3.valid_i = 1'b0;
    #1;
    check("drop_cnt_sat", DW'(bus3.drop_count_o), DW'(16'hFFFF));
    check("drop_valid_end", DW'(bus3.valid_groups_o), DW'(3'b000));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
